sd_io_arbiter: RTL and testbench
================================

Name: sd_io_arbiter

Overview:
- Shares the single io-controller sector channel (rd/wr/ack, lba, byte strobes) between two virtual SD card instances.
- Synchronises each card's asynchronous io_rd/io_wr requests into clk.
- Grants the channel round-robin, holds the grant for one whole sector transfer, then routes the ack and data strobes to the owner.
- Sits between the card instances and user_io; also fans config bytes (sent without ack) out to both cards.

Parameters:
- TIMEOUT, 24'hFFFFFF, clk cycles to wait in ISSUE for io_ack before abandoning the request.
- HOLDOFF, 3, cycles spent in RELEASE so the owner's synchronised request can drop.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req_rd  in  2  per-card sector read request (asynchronous; bit n = card n)
- req_wr  in  2  per-card sector write request (asynchronous)
- req_lba0  in  32  card 0 sector address
- req_lba1  in  32  card 1 sector address
- req_dout0  in  8  card 0 buffer byte toward io controller
- req_dout1  in  8  card 1 buffer byte toward io controller
- req_ack  out  2  per-card io_ack
- req_din  out  8  io_din broadcast to both cards
- req_din_strobe  out  2  per-card io_din_strobe
- req_dout_strobe  out  2  per-card io_dout_strobe
- io_rd  out  1  read request to io controller
- io_wr  out  1  write request to io controller
- io_lba  out  32  latched sector address of the owner
- io_dev  out  1  index of the owning card
- io_ack  in  1  io controller acknowledge, high for the whole transfer
- io_din  in  8  byte from io controller
- io_din_strobe  in  1  io_din valid strobe
- io_dout  out  8  owner's byte to io controller
- io_dout_strobe  in  1  io_dout consume strobe
- busy  out  1  state != IDLE
- timeout_err  out  1  sticky, set on request timeout

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- Reset values:
  - io_rd=0, io_wr=0, io_lba=0, io_dev=0, busy=0, timeout_err=0.
  - State=IDLE, last_grant=1 (card 0 wins first tie).
  - Synchronisers cleared.
- Request synchronisation: req_rd and req_wr each pass a 2-flop synchroniser (s_rd[1:0], s_wr[1:0]), giving 2 cycles of input latency.
- IDLE:
  - pend[n] = s_rd[n] | s_wr[n].
  - If any pend: grant = the card not equal to last_grant when both pend, otherwise the single pending card.
  - On grant, latch dir = s_rd[g] ? READ : WRITE (rd wins if both are set), latch io_lba = req_lba[g], set io_dev = g, go to ISSUE.
- ISSUE:
  - io_rd = (dir==READ), io_wr = (dir==WRITE), registered; first asserted 1 cycle after the grant decision.
  - Cycle counter increments each cycle.
  - io_ack sampled 1: drop io_rd/io_wr the next cycle, go to XFER.
  - Counter reaches TIMEOUT: drop io_rd/io_wr, set timeout_err, go to RELEASE.
- XFER: hold until io_ack is sampled 0 after having been 1, then go to RELEASE.
- RELEASE:
  - Lasts HOLDOFF cycles.
  - last_grant <= io_dev.
  - New requests are ignored; go to IDLE.
- Combinational routing, valid in ISSUE and XFER only:
  - req_ack[io_dev] = io_ack.
  - req_din_strobe[io_dev] = io_din_strobe.
  - req_dout_strobe[io_dev] = io_dout_strobe.
  - io_dout = io_dev ? req_dout1 : req_dout0.
  - Non-owner strobe and ack bits are 0.
- Config broadcast:
  - In IDLE with io_ack=0, io_din_strobe drives both req_din_strobe bits.
  - In IDLE, req_ack = 0 and req_dout_strobe = 0.
- Broadcast data: req_din = io_din at all times.
- io_ack high in IDLE (spurious): ignored, no routing, state unchanged.
- Requester drops its request during ISSUE: the transfer still completes; the arbiter only relies on io_ack.
- Reset asserted mid-transfer: all outputs return to reset values on the next clk edge; the transfer is abandoned.
- Fairness: a card never wins twice in a row while the other card is pending.

Test Plan:
- Card 0 rd pulse, lba=0x1234:
  - io_rd rises 3 cycles after the input edge, io_lba=0x1234, io_dev=0.
  - io_ack high 600 cycles with 512 io_din_strobes: exactly 512 pulses on req_din_strobe[0], none on [1].
  - Arbiter is IDLE HOLDOFF+1 cycles after io_ack falls.
- Card 1 wr, lba=7: io_wr=1, io_lba=7; 512 io_dout_strobes produce io_dout = req_dout1 and 512 req_dout_strobe[1] pulses.
- Both cards request in the same cycle after reset:
  - Card 0 is served first, then card 1.
  - Card 0 re-requests during card 1's service: served next; order is 0,1,0.
- 33 io_din_strobes with io_ack=0 in IDLE: both req_din_strobe bits pulse 33 times; io_rd and io_wr stay 0.
- TIMEOUT=16, card 0 rd, io_ack never asserted:
  - io_rd drops after 16 ISSUE cycles and timeout_err=1.
  - A subsequent card 1 request is still granted.
- Reset pulse during XFER: io_rd=0, busy=0, timeout_err=0 next cycle; a new card 0 request is granted normally.

Source files
------------

// File: rtl/sd_io_arbiter.sv
// Two-card arbiter for the io-controller sector channel: synchronises card requests,
// grants round-robin for a whole sector transfer and routes ack/strobes to the owner.
module sd_io_arbiter #(
  parameter logic [23:0] TIMEOUT = 24'hFFFFFF,
  parameter int unsigned HOLDOFF = 3
) (
  input  logic        clk,
  input  logic        reset,

  input  logic [1:0]  req_rd,
  input  logic [1:0]  req_wr,
  input  logic [31:0] req_lba0,
  input  logic [31:0] req_lba1,
  input  logic [7:0]  req_dout0,
  input  logic [7:0]  req_dout1,
  output logic [1:0]  req_ack,
  output logic [7:0]  req_din,
  output logic [1:0]  req_din_strobe,
  output logic [1:0]  req_dout_strobe,

  output logic        io_rd,
  output logic        io_wr,
  output logic [31:0] io_lba,
  output logic        io_dev,
  input  logic        io_ack,
  input  logic [7:0]  io_din,
  input  logic        io_din_strobe,
  output logic [7:0]  io_dout,
  input  logic        io_dout_strobe,

  output logic        busy,
  output logic        timeout_err
);

  typedef enum logic [1:0] {StIdle, StIssue, StXfer, StRelease} state_e;

  // Last RELEASE cycle index; HOLDOFF of 0 behaves like 1.
  localparam logic [7:0] HoldLast = (HOLDOFF > 1) ? 8'(HOLDOFF - 1) : 8'd0;

  state_e      state_q, state_d;
  logic [1:0]  rd_meta_q, rd_sync_q;
  logic [1:0]  wr_meta_q, wr_sync_q;
  logic        last_grant_q, last_grant_d;
  logic        io_rd_q, io_rd_d;
  logic        io_wr_q, io_wr_d;
  logic [31:0] io_lba_q, io_lba_d;
  logic        io_dev_q, io_dev_d;
  logic [23:0] cnt_q, cnt_d;
  logic [7:0]  hold_q, hold_d;
  logic        timeout_err_q, timeout_err_d;

  logic [1:0]  pend;
  logic        grant;
  logic        owned;

  assign pend  = rd_sync_q | wr_sync_q;
  // With both pending the card that did not go last wins.
  assign grant = (pend == 2'b11) ? ~last_grant_q : pend[1];
  assign owned = (state_q == StIssue) || (state_q == StXfer);

  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    io_rd_d       = io_rd_q;
    io_wr_d       = io_wr_q;
    io_lba_d      = io_lba_q;
    io_dev_d      = io_dev_q;
    cnt_d         = cnt_q;
    hold_d        = hold_q;
    timeout_err_d = timeout_err_q;

    unique case (state_q)
      StIdle: begin
        if (pend != 2'b00) begin
          io_dev_d = grant;
          io_lba_d = grant ? req_lba1 : req_lba0;
          io_rd_d  = rd_sync_q[grant];
          io_wr_d  = ~rd_sync_q[grant];
          cnt_d    = '0;
          state_d  = StIssue;
        end
      end
      StIssue: begin
        cnt_d = cnt_q + 24'd1;
        if (io_ack) begin
          io_rd_d = 1'b0;
          io_wr_d = 1'b0;
          state_d = StXfer;
        end else if (cnt_d == TIMEOUT) begin
          io_rd_d       = 1'b0;
          io_wr_d       = 1'b0;
          timeout_err_d = 1'b1;
          hold_d        = '0;
          state_d       = StRelease;
        end
      end
      StXfer: begin
        if (!io_ack) begin
          hold_d  = '0;
          state_d = StRelease;
        end
      end
      StRelease: begin
        last_grant_d = io_dev_q;
        hold_d       = hold_q + 8'd1;
        if (hold_q == HoldLast) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      rd_meta_q     <= '0;
      rd_sync_q     <= '0;
      wr_meta_q     <= '0;
      wr_sync_q     <= '0;
      last_grant_q  <= 1'b1;
      io_rd_q       <= 1'b0;
      io_wr_q       <= 1'b0;
      io_lba_q      <= '0;
      io_dev_q      <= 1'b0;
      cnt_q         <= '0;
      hold_q        <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      rd_meta_q     <= req_rd;
      rd_sync_q     <= rd_meta_q;
      wr_meta_q     <= req_wr;
      wr_sync_q     <= wr_meta_q;
      last_grant_q  <= last_grant_d;
      io_rd_q       <= io_rd_d;
      io_wr_q       <= io_wr_d;
      io_lba_q      <= io_lba_d;
      io_dev_q      <= io_dev_d;
      cnt_q         <= cnt_d;
      hold_q        <= hold_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  // Owner routing during a transfer; config bytes fan out to both cards while idle.
  always_comb begin
    req_ack         = '0;
    req_din_strobe  = '0;
    req_dout_strobe = '0;
    io_dout         = '0;
    if (owned) begin
      req_ack[io_dev_q]         = io_ack;
      req_din_strobe[io_dev_q]  = io_din_strobe;
      req_dout_strobe[io_dev_q] = io_dout_strobe;
      io_dout                   = io_dev_q ? req_dout1 : req_dout0;
    end else if ((state_q == StIdle) && !io_ack) begin
      req_din_strobe = {2{io_din_strobe}};
    end
  end

  assign req_din     = io_din;
  assign io_rd       = io_rd_q;
  assign io_wr       = io_wr_q;
  assign io_lba      = io_lba_q;
  assign io_dev      = io_dev_q;
  assign busy        = (state_q != StIdle);
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_sd_io_arbiter.sv
// Bench for sd_io_arbiter: directed scenarios plus random request rounds checked
// against a queue-free grant/ownership model of two competing cards.
module tb_sd_io_arbiter;

  localparam int HOLDOFF = 3;
  localparam int TMO     = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  req_rd = '0;
  logic [1:0]  req_wr = '0;
  logic [31:0] req_lba0 = '0;
  logic [31:0] req_lba1 = '0;
  logic [7:0]  req_dout0 = '0;
  logic [7:0]  req_dout1 = '0;
  logic [1:0]  req_ack;
  logic [7:0]  req_din;
  logic [1:0]  req_din_strobe;
  logic [1:0]  req_dout_strobe;
  logic        io_rd;
  logic        io_wr;
  logic [31:0] io_lba;
  logic        io_dev;
  logic        io_ack = 1'b0;
  logic [7:0]  io_din = '0;
  logic        io_din_strobe = 1'b0;
  logic [7:0]  io_dout;
  logic        io_dout_strobe = 1'b0;
  logic        busy;
  logic        timeout_err;

  sd_io_arbiter #(
    .TIMEOUT(24'(TMO)),
    .HOLDOFF(HOLDOFF)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req_rd(req_rd),
    .req_wr(req_wr),
    .req_lba0(req_lba0),
    .req_lba1(req_lba1),
    .req_dout0(req_dout0),
    .req_dout1(req_dout1),
    .req_ack(req_ack),
    .req_din(req_din),
    .req_din_strobe(req_din_strobe),
    .req_dout_strobe(req_dout_strobe),
    .io_rd(io_rd),
    .io_wr(io_wr),
    .io_lba(io_lba),
    .io_dev(io_dev),
    .io_ack(io_ack),
    .io_din(io_din),
    .io_din_strobe(io_din_strobe),
    .io_dout(io_dout),
    .io_dout_strobe(io_dout_strobe),
    .busy(busy),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: which cards are waiting, who went last, what each asked for.
  logic [1:0]  pend_m = '0;
  logic        last_m = 1'b1;
  logic [31:0] lba_m [2];
  logic        rd_m  [2];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic pick(input logic [1:0] p, input logic last);
    if (p == 2'b11) return ~last;
    return p[1];
  endfunction

  task automatic request(input logic c, input logic rd, input logic wr, input logic [31:0] lba);
    req_rd[c] = rd;
    req_wr[c] = wr;
    if (c) req_lba1 = lba;
    else   req_lba0 = lba;
    lba_m[c]  = lba;
    rd_m[c]   = rd;
    pend_m[c] = 1'b1;
  endtask

  task automatic do_reset();
    req_rd = '0;
    req_wr = '0;
    io_ack = 1'b0;
    io_din_strobe = 1'b0;
    io_dout_strobe = 1'b0;
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    pend_m = '0;
    last_m = 1'b1;
  endtask

  // Wait for the channel to be claimed and check the owner against the model.
  task automatic grant_check(output logic c, output logic rd);
    int n;
    logic e;
    n = 0;
    while (!(io_rd || io_wr) && n < 20) begin
      tick();
      n++;
    end
    check("grant_seen", 32'(io_rd | io_wr), 1);
    e = pick(pend_m, last_m);
    check("grant_dev", 32'(io_dev), 32'(e));
    check("grant_lba", io_lba, lba_m[e]);
    check("grant_rd", 32'(io_rd), 32'(rd_m[e]));
    check("grant_wr", 32'(io_wr), 32'(!rd_m[e]));
    check("grant_busy", 32'(busy), 1);
    c = e;
    rd = rd_m[e];
    pend_m[e] = 1'b0;
    last_m = e;
    req_rd[e] = 1'b0;
    req_wr[e] = 1'b0;
  endtask

  // Acknowledge for ncyc cycles, giving n data strobes, then release the channel.
  task automatic xfer(input logic c, input logic rd, input int n, input int ncyc);
    int left, got_own, got_other, route_err;
    logic s, own, other;
    repeat ($urandom_range(0, 4)) tick();
    left = n;
    got_own = 0;
    got_other = 0;
    route_err = 0;
    for (int i = 0; i < ncyc; i++) begin
      s = (left > 0) && ((left >= ncyc - i) || ($urandom_range(0, 1) == 1));
      if (s) left--;
      io_ack = 1'b1;
      io_din = 8'($urandom);
      req_dout0 = 8'($urandom);
      req_dout1 = 8'($urandom);
      io_din_strobe = rd && s;
      io_dout_strobe = !rd && s;
      #1;
      own   = rd ? req_din_strobe[c]  : req_dout_strobe[c];
      other = rd ? req_din_strobe[~c] : req_dout_strobe[~c];
      if (own) got_own++;
      if (other) got_other++;
      if (req_ack !== (2'b01 << c)) route_err++;
      if (io_dout !== (c ? req_dout1 : req_dout0)) route_err++;
      if (req_din !== io_din) route_err++;
      tick();
    end
    io_ack = 1'b0;
    io_din_strobe = 1'b0;
    io_dout_strobe = 1'b0;
    check("xfer_req_dropped", 32'(io_rd | io_wr), 0);
    check("xfer_own_strobes", got_own, n);
    check("xfer_other_strobes", got_other, 0);
    check("xfer_routing", route_err, 0);
    repeat (HOLDOFF) tick();
    check("release_busy", 32'(busy), 1);
    tick();
    check("idle_after_release", 32'(busy), 0);
  endtask

  logic        c, rd;
  logic [1:0]  m, dirs;
  int          n, cnt0, cnt1, bad, served;

  initial begin
    lba_m[0] = '0;
    lba_m[1] = '0;
    rd_m[0] = 1'b0;
    rd_m[1] = 1'b0;

    // Reset state
    repeat (2) tick();
    check("rst_io_rd", 32'(io_rd), 0);
    check("rst_io_wr", 32'(io_wr), 0);
    check("rst_io_lba", io_lba, 0);
    check("rst_io_dev", 32'(io_dev), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_timeout_err", 32'(timeout_err), 0);
    check("rst_req_ack", 32'(req_ack), 0);
    reset = 1'b0;
    tick();

    // Card 0 read: 3-cycle request latency, 512 bytes in 600 ack cycles
    request(1'b0, 1'b1, 1'b0, 32'h1234);
    tick();
    tick();
    check("lat2_io_rd", 32'(io_rd), 0);
    tick();
    check("lat3_io_rd", 32'(io_rd), 1);
    grant_check(c, rd);
    xfer(c, rd, 512, 600);

    // Card 1 write: io_dout follows req_dout1
    request(1'b1, 1'b0, 1'b1, 32'd7);
    grant_check(c, rd);
    xfer(c, rd, 512, 600);

    // Config bytes in idle go to both cards
    cnt0 = 0;
    cnt1 = 0;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      io_din_strobe = (i < 33);
      io_din = 8'($urandom);
      #1;
      if (req_din_strobe[0]) cnt0++;
      if (req_din_strobe[1]) cnt1++;
      if (io_rd || io_wr || busy || (req_ack != 2'b00) || (req_dout_strobe != 2'b00)) bad++;
      if (req_din !== io_din) bad++;
      tick();
    end
    io_din_strobe = 1'b0;
    check("cfg_strobes0", cnt0, 33);
    check("cfg_strobes1", cnt1, 33);
    check("cfg_side_effects", bad, 0);

    // Spurious ack in idle is ignored
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      io_ack = 1'b1;
      io_din_strobe = 1'($urandom);
      io_dout_strobe = 1'($urandom);
      #1;
      if ((req_ack | req_din_strobe | req_dout_strobe) != 2'b00) bad++;
      if (busy || io_rd || io_wr) bad++;
      tick();
    end
    io_ack = 1'b0;
    io_din_strobe = 1'b0;
    io_dout_strobe = 1'b0;
    check("spurious_ack", bad, 0);

    // Both cards at once after reset: order 0, 1, then 0 again
    do_reset();
    request(1'b0, 1'b1, 1'b0, 32'hA0A0);
    request(1'b1, 1'b1, 1'b0, 32'hB1B1);
    grant_check(c, rd);
    check("order_first", 32'(c), 0);
    xfer(c, rd, 8, 12);
    grant_check(c, rd);
    check("order_second", 32'(c), 1);
    request(1'b0, 1'b0, 1'b1, 32'hC0C0);
    xfer(c, rd, 8, 12);
    grant_check(c, rd);
    check("order_third", 32'(c), 0);
    xfer(c, rd, 8, 12);

    // Timeout: card 0 never acknowledged
    request(1'b0, 1'b1, 1'b0, 32'h55);
    grant_check(c, rd);
    n = 0;
    while (io_rd && n < 100) begin
      n++;
      tick();
    end
    check("timeout_len", n, TMO);
    check("timeout_err_set", 32'(timeout_err), 1);
    request(1'b1, 1'b0, 1'b1, 32'h66);
    grant_check(c, rd);
    xfer(c, rd, 4, 6);
    check("timeout_err_sticky", 32'(timeout_err), 1);

    // Reset in the middle of a transfer
    request(1'b0, 1'b1, 1'b0, 32'h77);
    grant_check(c, rd);
    io_ack = 1'b1;
    repeat (3) tick();
    reset = 1'b1;
    io_ack = 1'b0;
    tick();
    check("midrst_io_rd", 32'(io_rd), 0);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_timeout_err", 32'(timeout_err), 0);
    check("midrst_io_lba", io_lba, 0);
    reset = 1'b0;
    pend_m = '0;
    last_m = 1'b1;
    request(1'b0, 1'b1, 1'b0, 32'h88);
    grant_check(c, rd);
    xfer(c, rd, 16, 20);

    // Random rounds with optional re-requests during service
    for (int r = 0; r < 12; r++) begin
      served = 0;
      m = 2'($urandom_range(1, 3));
      for (int k = 0; k < 2; k++) begin
        if (m[k]) begin
          dirs = 2'($urandom_range(1, 3));
          request(k[0], dirs[0], dirs[1], $urandom);
        end
      end
      while (pend_m != 2'b00 && served < 6) begin
        grant_check(c, rd);
        served++;
        if (served < 3 && $urandom_range(0, 1) == 1) begin
          dirs = 2'($urandom_range(1, 3));
          request(c, dirs[0], dirs[1], $urandom);
        end
        n = $urandom_range(1, 24);
        xfer(c, rd, n, n + $urandom_range(0, 8));
      end
    end

    repeat (4) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
